cache_refill_ctrl: RTL and testbench

Miss-side engine for the 4xSA cache. The lookup path reads the tag/data arrays and reports a hit. This block is the writer to those arrays: it takes one miss at a time, writes back a dirty victim line to backing memory, fetches the new line word-by-word, writes it into the data array, then commits tag/valid/dirty. It sits between the cache arrays and a single-beat, request/response memory bus.

---
 rtl/cache_refill_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_refill_ctrl
//
// Miss-side engine for the 4-way set-associative cache. It takes one miss at a
// time. A dirty victim line is first written back to memory word by word. The
// missing line is then fetched word by word and written into the data array.
// Last, tag/valid/dirty for the set are committed. The memory side is a
// single-beat request/response bus with at most one read outstanding.
//
// Build option:
//   CACHE_REFILL_CWF_EN  - critical-word-first. The fill starts at the requested
//                          word and wraps around the line. When the macro is
//                          undefined, the fill always starts at word 0. The port
//                          list is the same in both builds.
//
// Ports:
//   clk, rst_n          clock (rising edge); asynchronous active-low reset
//   miss_valid/ready    miss handshake (miss_ready is registered)
//   miss_tag/index/word missing address fields
//   victim_dirty/tag    state of the victim way chosen by the lookup path
//   vic_rd_en/word      victim word read strobe to the data array
//   vic_rd_data         array read data, valid the cycle after vic_rd_en
//   mem_req_*           memory request (we=1 writeback, we=0 fill read)
//   mem_wdata           writeback data
//   mem_rdata_valid/    read data return
//   mem_rdata
//   fill_we/word/data   fill write into the data array
//   tag_we/tag_wr_tag   tag commit (valid=1, dirty=0)
//   crit_valid/data     pulse when the requested word returns
//   done                pulse when the refill is complete
// -----------------------------------------------------------------------------
module cache_refill_ctrl #(
  parameter int CACHE_LINES     = 256,
  parameter int LINE_SIZE_BYTES = 64,
  parameter int TAG_BITS        = 18,
  parameter int DATA_WIDTH      = 32,
  // Derived widths; keep at their defaults.
  parameter int IDX_W           = $clog2(CACHE_LINES),
  parameter int WORDS           = LINE_SIZE_BYTES * 8 / DATA_WIDTH,
  parameter int OFF_W           = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_valid,
  output logic                  miss_ready,
  input  logic [TAG_BITS-1:0]   miss_tag,
  input  logic [IDX_W-1:0]      miss_index,
  input  logic [OFF_W-1:0]      miss_word,
  input  logic                  victim_dirty,
  input  logic [TAG_BITS-1:0]   victim_tag,
  output logic                  vic_rd_en,
  output logic [OFF_W-1:0]      vic_rd_word,
  input  logic [DATA_WIDTH-1:0] vic_rd_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [31:0]           mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rdata_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  fill_we,
  output logic [OFF_W-1:0]      fill_word,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  tag_we,
  output logic [TAG_BITS-1:0]   tag_wr_tag,
  output logic                  crit_valid,
  output logic [DATA_WIDTH-1:0] crit_data,
  output logic                  done
);

`ifdef CACHE_REFILL_CWF_EN
  localparam bit CWF_EN = 1'b1;
`else
  localparam bit CWF_EN = 1'b0;
`endif

  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WB_RD,
    WB_REQ,
    FILL_REQ,
    FILL_WAIT,
    COMMIT
  } state_e;

  state_e                state_q, state_d;
  logic                  miss_ready_q;
  logic [OFF_W-1:0]      cnt_q;       // current word offset
  logic [OFF_W-1:0]      beat_q;      // fill beats completed, independent of offset
  logic [TAG_BITS-1:0]   tag_q;
  logic [IDX_W-1:0]      idx_q;
  logic [OFF_W-1:0]      word_q;
  logic [TAG_BITS-1:0]   vtag_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  wb_first_q;  // first WB_REQ cycle: array data is live on vic_rd_data

  logic accept;
  logic last_word;
  logic last_beat;

  // Offset of the first fill beat for a given requested word.
  function automatic logic [OFF_W-1:0] fill_start(input logic [OFF_W-1:0] w);
    return CWF_EN ? w : '0;
  endfunction

  assign accept    = (state_q == IDLE) && miss_valid && miss_ready_q;
  assign last_word = (cnt_q == LAST_OFF);
  assign last_beat = (beat_q == LAST_OFF);
  assign miss_ready = miss_ready_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together on the edge regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (accept) state_d = victim_dirty ? WB_RD : FILL_REQ;
      WB_RD:     state_d = WB_REQ;
      WB_REQ:    if (mem_req_ready) state_d = last_word ? FILL_REQ : WB_RD;
      FILL_REQ:  if (mem_req_ready) state_d = FILL_WAIT;
      FILL_WAIT: if (mem_rdata_valid) state_d = last_beat ? COMMIT : FILL_REQ;
      COMMIT:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_ready_q <= 1'b0;
      cnt_q        <= '0;
      beat_q       <= '0;
      tag_q        <= '0;
      idx_q        <= '0;
      word_q       <= '0;
      vtag_q       <= '0;
      wdata_q      <= '0;
      wb_first_q   <= 1'b0;
    end else begin
      miss_ready_q <= (state_d == IDLE);
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            tag_q  <= miss_tag;
            idx_q  <= miss_index;
            word_q <= miss_word;
            vtag_q <= victim_tag;
            beat_q <= '0;
            // Writeback always walks the whole line from word 0.
            cnt_q  <= victim_dirty ? '0 : fill_start(miss_word);
          end
        end
        WB_RD: wb_first_q <= 1'b1;
        WB_REQ: begin
          // Hold the word locally; the array only drives it for one cycle.
          if (wb_first_q) begin
            wdata_q    <= vic_rd_data;
            wb_first_q <= 1'b0;
          end
          if (mem_req_ready) cnt_q <= last_word ? fill_start(word_q) : cnt_q + OFF_W'(1);
        end
        FILL_WAIT: begin
          if (mem_rdata_valid) begin
            cnt_q  <= cnt_q + OFF_W'(1);
            beat_q <= beat_q + OFF_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    vic_rd_en     = 1'b0;
    vic_rd_word   = '0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_wdata     = '0;
    fill_we       = 1'b0;
    fill_word     = '0;
    fill_data     = '0;
    tag_we        = 1'b0;
    tag_wr_tag    = '0;
    crit_valid    = 1'b0;
    crit_data     = '0;
    done          = 1'b0;
    unique case (state_q)
      WB_RD: begin
        vic_rd_en   = 1'b1;
        vic_rd_word = cnt_q;
      end
      WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {vtag_q, idx_q, cnt_q, 2'b00};
        mem_wdata     = wb_first_q ? vic_rd_data : wdata_q;
      end
      FILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {tag_q, idx_q, cnt_q, 2'b00};
      end
      FILL_WAIT: begin
        fill_word = cnt_q;
        if (mem_rdata_valid) begin
          fill_we   = 1'b1;
          fill_data = mem_rdata;
          if (cnt_q == word_q) begin
            crit_valid = 1'b1;
            crit_data  = mem_rdata;
          end
        end
      end
      COMMIT: begin
        tag_we     = 1'b1;
        tag_wr_tag = tag_q;
        done       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_refill_ctrl
//
// Scoreboard bench for cache_refill_ctrl. Each miss pushes its expected memory
// requests, fill writes, critical word and commit into queues. A monitor pops
// and compares them whenever the DUT presents the matching strobe. A small
// memory/array model answers the bus and can stall every request.
// -----------------------------------------------------------------------------
module tb_cache_refill_ctrl;

  localparam int TAG_BITS = 18;
  localparam int IDX_W    = 8;
  localparam int OFF_W    = 4;
  localparam int DW       = 32;

`ifdef CACHE_REFILL_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic                miss_valid;
  logic                miss_ready;
  logic [TAG_BITS-1:0] miss_tag;
  logic [IDX_W-1:0]    miss_index;
  logic [OFF_W-1:0]    miss_word;
  logic                victim_dirty;
  logic [TAG_BITS-1:0] victim_tag;
  logic                vic_rd_en;
  logic [OFF_W-1:0]    vic_rd_word;
  logic [DW-1:0]       vic_rd_data;
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic                mem_req_we;
  logic [31:0]         mem_req_addr;
  logic [DW-1:0]       mem_wdata;
  logic                mem_rdata_valid;
  logic [DW-1:0]       mem_rdata;
  logic                fill_we;
  logic [OFF_W-1:0]    fill_word;
  logic [DW-1:0]       fill_data;
  logic                tag_we;
  logic [TAG_BITS-1:0] tag_wr_tag;
  logic                crit_valid;
  logic [DW-1:0]       crit_data;
  logic                done;

  always #5 clk = ~clk;

  cache_refill_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .miss_valid      (miss_valid),
    .miss_ready      (miss_ready),
    .miss_tag        (miss_tag),
    .miss_index      (miss_index),
    .miss_word       (miss_word),
    .victim_dirty    (victim_dirty),
    .victim_tag      (victim_tag),
    .vic_rd_en       (vic_rd_en),
    .vic_rd_word     (vic_rd_word),
    .vic_rd_data     (vic_rd_data),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_we      (mem_req_we),
    .mem_req_addr    (mem_req_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_rdata       (mem_rdata),
    .fill_we         (fill_we),
    .fill_word       (fill_word),
    .fill_data       (fill_data),
    .tag_we          (tag_we),
    .tag_wr_tag      (tag_wr_tag),
    .crit_valid      (crit_valid),
    .crit_data       (crit_data),
    .done            (done)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } mem_exp_t;
  typedef struct { logic [3:0] word; logic [31:0] data; } fill_exp_t;
  typedef struct { logic [31:0] data; int beat; } crit_exp_t;
  typedef struct { logic [17:0] tag; int lat; } tag_exp_t;

  mem_exp_t  mem_q[$];
  fill_exp_t fill_q[$];
  crit_exp_t crit_q[$];
  tag_exp_t  tag_q[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int stall_cycles = 0;
  int tag_cnt = 0;
  int beat_cnt = 0;
  int acc_cyc = 0;
  int exp_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_addr(input logic [17:0] t, input logic [7:0] i,
                                          input logic [3:0] w);
    return {t, i, w, 2'b00};
  endfunction

  task automatic check_outputs_zero(input string name);
    check(name, {miss_ready, vic_rd_en, vic_rd_word, mem_req_valid, mem_req_we,
                 mem_req_addr, mem_wdata, fill_we, fill_word, fill_data, tag_we,
                 tag_wr_tag, crit_valid, crit_data, done}, '0);
  endtask

  // ---------------------------------------------------------------------------
  // Memory bus and victim array model
  // ---------------------------------------------------------------------------
  initial begin
    logic        rd_pend, ret, spur;
    logic [3:0]  rd_word;
    logic [31:0] ret_addr;
    int          wait_cnt;
    wait_cnt = 0;
    ret_addr = '0;
    rd_word  = '0;
    mem_req_ready   = 1'b1;
    mem_rdata_valid = 1'b0;
    mem_rdata       = '0;
    vic_rd_data     = '0;
    forever begin
      @(negedge clk);
      rd_pend = rst_n && vic_rd_en;
      rd_word = vic_rd_word;
      ret  = 1'b0;
      spur = 1'b0;
      if (!rst_n) begin
        wait_cnt = 0;
      end else if (mem_req_valid) begin
        if (mem_req_ready) begin
          ret      = !mem_req_we;
          ret_addr = mem_req_addr;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
          // Still stalled next cycle: inject a stray return the DUT must ignore.
          spur = (wait_cnt < stall_cycles);
        end
      end
      @(posedge clk);
      #1;
      vic_rd_data     = rd_pend ? 32'h0000_A000 + 32'(rd_word) : 32'hDEAD_BEEF;
      mem_rdata_valid = (ret || spur) && rst_n;
      mem_rdata       = ret ? ret_addr : 32'hBADB_AD00;
      mem_req_ready   = (wait_cnt >= stall_cycles);
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin
    logic        stalled, prev_done, h_we;
    logic [31:0] h_addr, h_wdata;
    mem_exp_t    me;
    fill_exp_t   fe;
    crit_exp_t   ce;
    tag_exp_t    te;
    stalled = 1'b0;
    prev_done = 1'b0;
    h_we = 1'b0;
    h_addr = '0;
    h_wdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled   = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (miss_valid && miss_ready) begin
          acc_cyc  = cyc;
          beat_cnt = 0;
        end

        if (stalled) begin
          check("stall_valid_held", mem_req_valid, 1'b1);
          if (mem_req_valid) begin
            check("stall_we_held", mem_req_we, h_we);
            check("stall_addr_held", mem_req_addr, h_addr);
            check("stall_wdata_held", mem_wdata, h_wdata);
          end
        end
        if (mem_req_valid) begin
          if (mem_req_ready) begin
            stalled = 1'b0;
            if (mem_q.size() == 0) check("mem_req_expected", 1'b0, 1'b1);
            else begin
              me = mem_q.pop_front();
              check("mem_we", mem_req_we, me.we);
              check("mem_addr", mem_req_addr, me.addr);
              if (me.we) check("mem_wdata", mem_wdata, me.wdata);
            end
          end else begin
            stalled = 1'b1;
            h_we    = mem_req_we;
            h_addr  = mem_req_addr;
            h_wdata = mem_wdata;
          end
        end else begin
          stalled = 1'b0;
        end

        if (fill_we) begin
          if (fill_q.size() == 0) check("fill_expected", 1'b0, 1'b1);
          else begin
            fe = fill_q.pop_front();
            check("fill_word", fill_word, fe.word);
            check("fill_data", fill_data, fe.data);
          end
          if (crit_valid) begin
            if (crit_q.size() == 0) check("crit_expected", 1'b0, 1'b1);
            else begin
              ce = crit_q.pop_front();
              check("crit_data", crit_data, ce.data);
              check("crit_beat", beat_cnt, ce.beat);
            end
          end
          beat_cnt++;
        end else if (crit_valid) begin
          check("crit_without_fill", 1'b1, 1'b0);
        end

        if (tag_we) begin
          tag_cnt++;
          check("done_with_commit", done, 1'b1);
          check("beats_before_commit", beat_cnt, 16);
          if (tag_q.size() == 0) check("commit_expected", 1'b0, 1'b1);
          else begin
            te = tag_q.pop_front();
            check("tag_wr_tag", tag_wr_tag, te.tag);
            if (te.lat >= 0) check("done_latency", cyc - acc_cyc, te.lat);
          end
        end else if (done) begin
          check("done_without_commit", 1'b1, 1'b0);
        end
        if (done) check("done_single_pulse", prev_done, 1'b0);
        prev_done = done;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic start_miss(input logic [17:0] t, input logic [7:0] idx, input logic [3:0] w,
                            input bit dirty, input logic [17:0] vt);
    logic [3:0] start, off;
    bit ok;
    start = CWF ? w : 4'd0;
    if (dirty)
      for (int k = 0; k < 16; k++)
        mem_q.push_back('{we: 1'b1, addr: mk_addr(vt, idx, 4'(k)), wdata: 32'h0000_A000 + 32'(k)});
    for (int b = 0; b < 16; b++) begin
      off = start + 4'(b);
      mem_q.push_back('{we: 1'b0, addr: mk_addr(t, idx, off), wdata: 32'h0});
      fill_q.push_back('{word: off, data: mk_addr(t, idx, off)});
    end
    crit_q.push_back('{data: mk_addr(t, idx, w), beat: CWF ? 0 : int'(w)});
    tag_q.push_back('{tag: t, lat: (stall_cycles != 0) ? -1 : (dirty ? 65 : 33)});
    exp_done++;

    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (miss_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("miss_ready_before_issue", ok, 1'b1);
    miss_valid   = 1'b1;
    miss_tag     = t;
    miss_index   = idx;
    miss_word    = w;
    victim_dirty = dirty;
    victim_tag   = vt;
    @(posedge clk);
    #1;
    // Keep a bogus request asserted while busy; it must be ignored.
    miss_tag     = ~t;
    miss_index   = ~idx;
    miss_word    = ~w;
    victim_dirty = ~dirty;
    victim_tag   = ~vt;
    repeat (5) @(posedge clk);
    #1;
    miss_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      #1;
      if (tag_cnt >= exp_done) begin
        ok = 1'b1;
        break;
      end
    end
    check("refill_completed", ok, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int tag_before;
    bit reached;
    rst_n        = 1'b0;
    miss_valid   = 1'b0;
    miss_tag     = '0;
    miss_index   = '0;
    miss_word    = '0;
    victim_dirty = 1'b0;
    victim_tag   = '0;

    // Reset: outputs quiet, miss_ready rises one edge after release.
    repeat (3) begin
      @(negedge clk);
      #1;
      check_outputs_zero("reset_outputs_zero");
    end
    #1 rst_n = 1'b1;
    #1 check("ready_before_first_edge", miss_ready, 1'b0);
    @(posedge clk);
    #1 check("ready_after_release", miss_ready, 1'b1);

    // Clean miss, zero-wait memory.
    start_miss(18'h002A5, 8'h13, 4'd5, 1'b0, 18'h00000);
    wait_done();

    // Dirty miss: full writeback precedes the fill.
    start_miss(18'h002A5, 8'h13, 4'd3, 1'b1, 18'h00001);
    wait_done();

    // Backpressure on every request, extreme tag/index values.
    stall_cycles = 4;
    start_miss(18'h3FFFF, 8'hFF, 4'd0, 1'b1, 18'h2AAAA);
    wait_done();
    stall_cycles = 0;

    // Requested word 14: wrap order in CWF build, late critical beat otherwise.
    start_miss(18'h00001, 8'h00, 4'd14, 1'b0, 18'h00000);
    wait_done();

    // Reset mid-fill after 7 beats: no commit, engine returns to idle.
    tag_before = tag_cnt;
    start_miss(18'h0BEEF, 8'h40, 4'd9, 1'b0, 18'h00000);
    reached = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      #1;
      if (beat_cnt >= 7) begin
        reached = 1'b1;
        break;
      end
    end
    check("abort_beats_seen", beat_cnt, 7);
    check("abort_point_reached", reached, 1'b1);
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("abort_reset_outputs_zero");
    repeat (2) begin
      @(negedge clk);
      #1;
      check_outputs_zero("abort_reset_outputs_zero");
    end
    mem_q.delete();
    fill_q.delete();
    crit_q.delete();
    tag_q.delete();
    exp_done--;
    #1 rst_n = 1'b1;
    #1 check("abort_ready_before_edge", miss_ready, 1'b0);
    @(posedge clk);
    #1 check("abort_ready_after_release", miss_ready, 1'b1);
    check("abort_no_commit", tag_cnt, tag_before);

    // Next miss after the abort runs to completion.
    start_miss(18'h12345, 8'h7E, 4'd15, 1'b1, 18'h00ABC);
    wait_done();

    check("total_commits", tag_cnt, 5);
    check("mem_queue_drained", mem_q.size(), 0);
    check("fill_queue_drained", fill_q.size(), 0);
    check("crit_queue_drained", crit_q.size(), 0);
    check("tag_queue_drained", tag_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
